// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Field positions follow the ARM-subset instruction encoding.
package fetch_pkg;

   typedef enum logic {
      FETCH = 1'b0,
      FULL  = 1'b1
   } fetch_state_t;

   localparam int INSTR_W     = 32;
   localparam int PC_INC      = 4;
   localparam int PC_READ_OFS = 8;

   localparam int COND_MSB  = 31;
   localparam int OP_LSB    = 26;
   localparam int FUNCT_LSB = 20;
   localparam int RD_LSB    = 12;

endpackage

// File: rtl/fetch_if.sv
// Instruction memory request/acknowledge bus.
// master = fetch unit, slave = instruction memory.
interface fetch_if #(
   parameter int ADDR_W = 32
);

   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [31:0]       imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register with load enable and next-PC mux.
// Branch targets are word-aligned by clearing bits [1:0].
module fetch_pc_reg #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld,
   input  logic              pc_src,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic [ADDR_W-1:0] seq_pc,
   output logic [ADDR_W-1:0] pc
);

   logic [ADDR_W-1:0] pc_d;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] tgt_aligned;

   assign tgt_aligned = branch_target & ~ADDR_W'(3);

   // Select redirect or sequential PC when loading.
   always_comb begin
      pc_d = pc_q;
      if (ld) begin
         pc_d = pc_src ? tgt_aligned : seq_pc;
      end
   end

   // PC flop, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) pc_q <= RESET_PC;
      else      pc_q <= pc_d;
   end

   assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, imem handshake, instruction buffer.
// Optional perf counters enabled by defining FETCH_PERF_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   fetch_if.master            imem,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] Instr,
   output logic [3:0]         Cond,
   output logic [1:0]         Op,
   output logic [5:0]         Funct,
   output logic [3:0]         Rd,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic [ADDR_W-1:0]  PCPlus8,
   input  logic               PCSrc,
   input  logic [ADDR_W-1:0]  branch_target
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]        fetch_count,
   output logic [31:0]        redirect_count
`endif
);

   fetch_state_t       state_d, state_q;
   logic [INSTR_W-1:0] instr_d, instr_q;
   logic [ADDR_W-1:0]  instr_pc_d, instr_pc_q;
   logic [ADDR_W-1:0]  pc;
   logic [ADDR_W-1:0]  seq_pc;
   logic               accept;

   assign accept = (state_q == FULL) && instr_ready;
   assign seq_pc = instr_pc_q + ADDR_W'(PC_INC);

   fetch_pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk           (clk),
      .rst           (rst),
      .ld            (accept),
      .pc_src        (PCSrc),
      .branch_target (branch_target),
      .seq_pc        (seq_pc),
      .pc            (pc)
   );

   // Next-state: capture word on ack, release on ready.
   always_comb begin
      state_d    = state_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      unique case (state_q)
         FETCH: begin
            if (imem.imem_ack) begin
               instr_d    = imem.imem_rdata;
               instr_pc_d = pc;
               state_d    = FULL;
            end
         end
         FULL: begin
            if (instr_ready) state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   // FSM and instruction buffer flops.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= FETCH;
         instr_q    <= '0;
         instr_pc_q <= '0;
      end else begin
         state_q    <= state_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
      end
   end

   // Request is suppressed while reset is held so none leaks out.
   assign imem.imem_req  = rst && (state_q == FETCH);
   assign imem.imem_addr = pc;

   assign instr_valid = (state_q == FULL);
   assign Instr       = instr_q;
   assign Cond        = instr_q[COND_MSB -: 4];
   assign Op          = instr_q[OP_LSB +: 2];
   assign Funct       = instr_q[FUNCT_LSB +: 6];
   assign Rd          = instr_q[RD_LSB +: 4];
   assign instr_pc    = instr_pc_q;
   assign PCPlus8     = instr_pc_q + ADDR_W'(PC_READ_OFS);

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_count_d, fetch_count_q;
   logic [31:0] redirect_count_d, redirect_count_q;

   // Count accepted instructions and taken redirects.
   always_comb begin
      fetch_count_d    = fetch_count_q;
      redirect_count_d = redirect_count_q;
      if (accept) begin
         fetch_count_d = fetch_count_q + 32'd1;
         if (PCSrc) redirect_count_d = redirect_count_q + 32'd1;
      end
   end

   // Counter flops.
   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_count_q    <= '0;
         redirect_count_q <= '0;
      end else begin
         fetch_count_q    <= fetch_count_d;
         redirect_count_q <= redirect_count_d;
      end
   end

   assign fetch_count    = fetch_count_q;
   assign redirect_count = redirect_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit.
// Perf counter checks compile in when FETCH_PERF_EN is defined.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        instr_ready = 1'b0;
   logic        PCSrc = 1'b0;
   logic [31:0] branch_target = '0;
   logic        instr_valid;
   logic [31:0] Instr;
   logic [3:0]  Cond;
   logic [1:0]  Op;
   logic [5:0]  Funct;
   logic [3:0]  Rd;
   logic [31:0] instr_pc;
   logic [31:0] PCPlus8;
`ifdef FETCH_PERF_EN
   logic [31:0] fetch_count;
   logic [31:0] redirect_count;
`endif

   fetch_if #(.ADDR_W(32)) bus ();

   fetch_unit #(
      .ADDR_W   (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .imem          (bus.master),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .Instr         (Instr),
      .Cond          (Cond),
      .Op            (Op),
      .Funct         (Funct),
      .Rd            (Rd),
      .instr_pc      (instr_pc),
      .PCPlus8       (PCPlus8),
      .PCSrc         (PCSrc),
      .branch_target (branch_target)
`ifdef FETCH_PERF_EN
      ,
      .fetch_count    (fetch_count),
      .redirect_count (redirect_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] p8;
      logic [15:0] fields;
      logic        stable_ok;
      logic        valid_ok;
      logic        to;
   } obs_t;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] exp_pc = '0;
   logic [63:0] sb_q[$];

   // Drive one full fetch/accept; leaves the bench at a negedge.
   task automatic fetch_one(input int ack_wait, input int rdy_wait,
                            input logic src, input logic [31:0] tgt,
                            input logic [31:0] word, output obs_t o);
      int n;
      logic [31:0] held;
      o = '{default: '0};
      o.stable_ok = 1'b1;
      n = 0;
      while (bus.imem_req !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      if (bus.imem_req !== 1'b1) begin
         o.to = 1'b1;
         return;
      end
      o.addr = bus.imem_addr;
      for (int i = 0; i < ack_wait; i++) begin
         bus.imem_ack = 1'b0;
         @(negedge clk);
         if (bus.imem_req !== 1'b1 || bus.imem_addr !== o.addr ||
             instr_valid !== 1'b0)
            o.stable_ok = 1'b0;
      end
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = word;
      sb_q.push_back({word, exp_pc});
      @(negedge clk);
      bus.imem_rdata = ~word;
      o.valid_ok = (instr_valid === 1'b1) && (bus.imem_req === 1'b0);
      held = Instr;
      for (int i = 0; i < rdy_wait; i++) begin
         instr_ready   = 1'b0;
         PCSrc         = 1'b1;
         branch_target = 32'hDEAD_BEE0;
         @(negedge clk);
         if (instr_valid !== 1'b1 || Instr !== held ||
             bus.imem_req !== 1'b0)
            o.stable_ok = 1'b0;
      end
      o.instr  = Instr;
      o.pc     = instr_pc;
      o.p8     = PCPlus8;
      o.fields = {Cond, Op, Funct, Rd};
      bus.imem_ack  = 1'b0;
      instr_ready   = 1'b1;
      PCSrc         = src;
      branch_target = tgt;
      @(negedge clk);
      instr_ready   = 1'b0;
      PCSrc         = 1'b0;
      branch_target = '0;
      exp_pc = src ? (tgt & ~32'h3) : exp_pc + 32'd4;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         bus.imem_ack   = i[0];
         bus.imem_rdata = $urandom;
         @(negedge clk);
      end
      vectors++;
      if (bus.imem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_req got %b want 0", bus.imem_req);
      end
      vectors++;
      if (bus.imem_addr !== 32'h0) begin
         miscompares++;
         $display("FAIL rst_addr got %h want 0", bus.imem_addr);
      end
      vectors++;
      if (instr_valid !== 1'b0 || Instr !== 32'h0 ||
          {Cond, Op, Funct, Rd} !== 16'h0) begin
         miscompares++;
         $display("FAIL rst_instr got v=%b %h want 0", instr_valid, Instr);
      end
      vectors++;
      if (instr_pc !== 32'h0 || PCPlus8 !== 32'h8) begin
         miscompares++;
         $display("FAIL rst_pc got %h/%h want 0/8", instr_pc, PCPlus8);
      end
      bus.imem_ack = 1'b0;
      rst = 1'b1;
      exp_pc = 32'h0;
      #1;
      vectors++;
      if (bus.imem_req !== 1'b1) begin
         miscompares++;
         $display("FAIL first_req got %b want 1", bus.imem_req);
      end
   endtask

   task automatic test_first();
      obs_t o;
      logic [63:0] e;
      fetch_one(0, 0, 1'b0, 32'h0, 32'h1111_2222, o);
      vectors++;
      if (o.to !== 1'b0 || o.addr !== 32'h0 || o.valid_ok !== 1'b1) begin
         miscompares++;
         $display("FAIL first_fetch got to=%b a=%h v=%b want 0/0/1",
                  o.to, o.addr, o.valid_ok);
      end
      e = sb_q.pop_front();
      vectors++;
      if ({o.instr, o.pc} !== e || o.p8 !== 32'h8) begin
         miscompares++;
         $display("FAIL first_sb got %h/%h/%h want %h p8=8",
                  o.instr, o.pc, o.p8, e);
      end
   endtask

   task automatic test_sequential();
      obs_t o;
      logic [63:0] e;
      logic [31:0] ea;
      for (int k = 1; k < 4; k++) begin
         ea = exp_pc;
         fetch_one(0, 0, 1'b0, 32'h0, 32'hA000_0000 + k, o);
         vectors++;
         if (o.to !== 1'b0 || o.addr !== ea || o.valid_ok !== 1'b1 ||
             ea !== 32'(k * 4)) begin
            miscompares++;
            $display("FAIL seq_addr%0d got %h v=%b want %h", k,
                     o.addr, o.valid_ok, 32'(k * 4));
         end
         e = sb_q.pop_front();
         vectors++;
         if ({o.instr, o.pc} !== e || o.p8 !== ea + 32'd8) begin
            miscompares++;
            $display("FAIL seq_sb%0d got %h/%h want %h", k,
                     o.instr, o.pc, e);
         end
      end
   endtask

   task automatic test_backpressure();
      obs_t o;
      logic [63:0] e;
      fetch_one(0, 3, 1'b0, 32'h0, 32'hE3A0_1005, o);
      vectors++;
      if (o.to !== 1'b0 || o.stable_ok !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_stable got to=%b st=%b want 0/1",
                  o.to, o.stable_ok);
      end
      vectors++;
      if (o.fields !== {4'hE, 2'b00, 6'h3A, 4'h1}) begin
         miscompares++;
         $display("FAIL bp_fields got %h want e3a1", o.fields);
      end
      e = sb_q.pop_front();
      vectors++;
      if ({o.instr, o.pc} !== e) begin
         miscompares++;
         $display("FAIL bp_sb got %h/%h want %h", o.instr, o.pc, e);
      end
   endtask

   task automatic test_branch();
      obs_t o;
      logic [63:0] e;
      fetch_one(0, 2, 1'b1, 32'h0000_0103, 32'h0A00_0010, o);
      e = sb_q.pop_front();
      vectors++;
      if (o.stable_ok !== 1'b1 || {o.instr, o.pc} !== e) begin
         miscompares++;
         $display("FAIL br_hold got st=%b %h/%h want %h",
                  o.stable_ok, o.instr, o.pc, e);
      end
      vectors++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
         miscompares++;
         $display("FAIL br_target got %b/%h want 1/00000100",
                  bus.imem_req, bus.imem_addr);
      end
      fetch_one(0, 0, 1'b1, 32'hFFFF_FFFE, 32'h1234_5678, o);
      e = sb_q.pop_front();
      vectors++;
      if (o.addr !== 32'h100 || {o.instr, o.pc} !== e) begin
         miscompares++;
         $display("FAIL br_fetch got %h %h/%h want 100 %h",
                  o.addr, o.instr, o.pc, e);
      end
   endtask

   task automatic test_wrap();
      obs_t o;
      logic [63:0] e;
      fetch_one(2, 0, 1'b0, 32'h0, 32'h5555_AAAA, o);
      vectors++;
      if (o.to !== 1'b0 || o.addr !== 32'hFFFF_FFFC ||
          o.stable_ok !== 1'b1) begin
         miscompares++;
         $display("FAIL wrap_wait got %h st=%b want fffffffc/1",
                  o.addr, o.stable_ok);
      end
      e = sb_q.pop_front();
      vectors++;
      if ({o.instr, o.pc} !== e || o.p8 !== 32'h4) begin
         miscompares++;
         $display("FAIL wrap_p8 got %h/%h/%h want %h p8=4",
                  o.instr, o.pc, o.p8, e);
      end
      vectors++;
      if (bus.imem_addr !== 32'h0 || exp_pc !== 32'h0) begin
         miscompares++;
         $display("FAIL wrap_next got %h want 0", bus.imem_addr);
      end
   endtask

   task automatic test_reset_mid();
      obs_t o;
      logic [63:0] e;
      fetch_one(0, 0, 1'b0, 32'h0, 32'h7777_0000, o);
      void'(sb_q.pop_front());
      bus.imem_ack = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.imem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_req got %b want 0", bus.imem_req);
      end
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      bus.imem_ack = 1'b0;
      vectors++;
      if (instr_valid !== 1'b0 || Instr !== 32'h0) begin
         miscompares++;
         $display("FAIL mid_valid got %b %h want 0", instr_valid, Instr);
      end
      rst = 1'b1;
      exp_pc = 32'h0;
      fetch_one(1, 0, 1'b0, 32'h0, 32'h0C0C_0C0C, o);
      e = sb_q.pop_front();
      vectors++;
      if (o.addr !== 32'h0 || {o.instr, o.pc} !== e) begin
         miscompares++;
         $display("FAIL mid_restart got %h %h/%h want 0 %h",
                  o.addr, o.instr, o.pc, e);
      end
   endtask

`ifdef FETCH_PERF_EN
   task automatic test_perf();
      obs_t o;
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (fetch_count !== 32'h0 || redirect_count !== 32'h0) begin
         miscompares++;
         $display("FAIL perf_rst got %0d/%0d want 0/0",
                  fetch_count, redirect_count);
      end
      rst = 1'b1;
      exp_pc = 32'h0;
      for (int k = 0; k < 4; k++) begin
         fetch_one(k % 2, 1, k == 2, 32'h40, 32'h100 + k, o);
         void'(sb_q.pop_front());
      end
      vectors++;
      if (fetch_count !== 32'd4 || redirect_count !== 32'd1) begin
         miscompares++;
         $display("FAIL perf_cnt got %0d/%0d want 4/1",
                  fetch_count, redirect_count);
      end
   endtask
`endif

   initial begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = '0;
      test_reset();
      test_first();
      test_sequential();
      test_backpressure();
      test_branch();
      test_wrap();
      test_reset_mid();
`ifdef FETCH_PERF_EN
      test_perf();
`endif
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch unit feeding the control unit and datapath of the ARM-subset processor. It holds the program counter and fetches 32-bit words from instruction memory over a request/acknowledge handshake. Each fetched word is presented as a buffered instruction with its decoded fields (Cond, Op, Funct, Rd). It takes the control unit's PCSrc and the datapath's branch target back to redirect the PC.

## Interface
Parameters:
- ADDR_W, 32, PC and memory address width
- RESET_PC, 32'h0000_0000, PC value loaded by reset

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  ADDR_W  word address being fetched, always current PC
- imem_ack  in  1  memory has returned imem_rdata this cycle
- imem_rdata  in  32  instruction word, sampled only when imem_ack=1 in FETCH
- instr_valid  out  1  Instr and fields hold a valid instruction
- instr_ready  in  1  downstream consumes the instruction this cycle
- Instr  out  32  buffered instruction word
- Cond  out  4  Instr[31:28]
- Op  out  2  Instr[27:26]
- Funct  out  6  Instr[25:20]
- Rd  out  4  Instr[15:12]
- instr_pc  out  ADDR_W  address of the buffered instruction
- PCPlus8  out  ADDR_W  instr_pc + 8, the architectural PC read value
- PCSrc  in  1  branch/PC-write taken, qualified by the control unit's CondEx
- branch_target  in  ADDR_W  redirect address; bits [1:0] are forced to 0

## Operation
- FSM states are FETCH and FULL. Reset enters FETCH with PC = RESET_PC.
- In FETCH:
  - imem_req=1 and imem_addr=PC, both held stable until imem_ack.
  - On imem_ack, imem_rdata→Instr and PC→instr_pc, and the FSM moves to FULL.
- In FULL:
  - imem_req=0 and instr_valid=1.
  - Instr and fields are held stable while instr_ready=0.
  - On instr_ready=1:
    - PC ← {branch_target[ADDR_W-1:2],2'b00} if PCSrc=1, else PC ← instr_pc + 4.
    - The FSM returns to FETCH.
- PCSrc and branch_target are sampled only on the instr_ready=1 cycle in FULL. They are ignored otherwise.
- imem_ack outside FETCH is ignored (no state change).
- Arithmetic is modulo 2^ADDR_W. PC wraps from 32'hFFFF_FFFC to 0. PCPlus8 wraps the same way.
- Field outputs are pure slices of Instr and are valid only while instr_valid=1.

## Timing
- Reset values while rst=0:
  - imem_req=0, imem_addr=RESET_PC
  - instr_valid=0, Instr=0, Cond/Op/Funct/Rd=0
  - instr_pc=0, PCPlus8=8
- First imem_req=1 occurs in the first cycle with rst=1.
- Same-cycle ack is allowed (combinational memory).
- instr_valid rises in the cycle after imem_ack.
- Timing per instruction:
  - Minimum 2 cycles (FETCH+ack, FULL+ready).
  - Each extra ack wait adds 1 cycle, and each cycle of instr_ready=0 in FULL adds 1 cycle.
- A redirect takes effect on the very next imem_addr; no wrong-path fetch is ever issued.
- Reset asserted mid-fetch:
  - imem_req drops in the next cycle and the outstanding transaction is abandoned.
  - An ack arriving during or after reset, before the new FETCH, is ignored.
- Reset asserted in FULL drops instr_valid in the next cycle.

## Configuration
- FETCH_PERF_EN defined:
  - Adds outputs fetch_count[31:0] and redirect_count[31:0], both reset to 0 and wrapping at 2^32.
  - fetch_count increments on each accepted instruction (FULL & instr_ready).
  - redirect_count increments when that acceptance also has PCSrc=1.
- FETCH_PERF_EN undefined: the ports and counters do not exist. All other behaviour is identical.

## Structure
- Package fetch_pkg holds:
  - typedef enum logic {FETCH, FULL} fetch_state_t
  - INSTR_W=32, PC_INC=4, PC_READ_OFS=8
  - field bit positions: COND_MSB=31, OP_LSB=26, FUNCT_LSB=20, RD_LSB=12
- One sub-module, fetch_pc_reg: ADDR_W-bit register with load enable, synchronous active-low reset to RESET_PC, next-PC mux input.

## Test plan
- Reset release with RESET_PC=0 and ack the same cycle → imem_addr=0, instr_valid=1 next cycle, instr_pc=0, PCPlus8=8.
- Sequential flow, ack same cycle, ready=1 always, PCSrc=0 → imem_addr sequence 0,4,8,C with instr_valid high every other cycle.
- Backpressure with ready=0 for 3 cycles in FULL, Instr=32'hE3A0_1005 → Instr, Cond=4'hE, Op=2'b00, Funct=6'h3A, Rd=4'h1 held stable; no imem_req.
- Branch: accept at instr_pc=8 with PCSrc=1, branch_target=32'h0000_0103 → next imem_addr=32'h100. PCSrc=1 while ready=0 changes nothing.
- Wrap and delay: PC=32'hFFFF_FFFC, ack after 2 wait cycles → imem_addr stable for 3 cycles, then the next fetch is at 0.
- Reset during wait: rst=0 while FETCH awaits ack, late ack delivered → no instr_valid, restart at RESET_PC. With FETCH_PERF_EN, after 4 accepts including 1 redirect → fetch_count=4, redirect_count=1.
